// File: rtl/copro_frame_sequencer.sv
// Frame sequencer between a UART byte stream and a wide-word coprocessor.
// Optional WAIT watchdog enabled by defining COPRO_SEQ_TIMEOUT_EN.
module copro_frame_sequencer #(
    parameter int unsigned WIDTH_DIN      = 128,
    parameter int unsigned WIDTH_DOUT     = 128,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [WIDTH_DIN-1:0]  din,
    output logic                  din_valid,
    input  logic [WIDTH_DOUT-1:0] dout,
    input  logic                  dout_valid,
    output logic [5:0]            control,
    output logic                  busy,
    output logic                  overrun
);
    localparam int unsigned NIN  = WIDTH_DIN / 8;
    localparam int unsigned NOUT = WIDTH_DOUT / 8;
    localparam int unsigned NMAX = (NIN > NOUT) ? NIN : NOUT;
    localparam int unsigned CW   = $clog2(NMAX + 1);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, SEND, ERR} state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [WIDTH_DOUT-1:0] shreg;
    logic                  capture;

`ifdef COPRO_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wcnt;
`endif

    // ISSUE also accepts a result so a zero-latency coprocessor is not missed.
    assign capture = dout_valid && (state == ISSUE || state == WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            din       <= '0;
            din_valid <= 1'b0;
            control   <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            shreg     <= '0;
`ifdef COPRO_SEQ_TIMEOUT_EN
            wcnt      <= '0;
`endif
        end else begin
            if (rx_valid && (state inside {ISSUE, WAIT, SEND, ERR}))
                overrun <= 1'b1;

            if (capture) begin
                shreg    <= dout;
                tx_data  <= dout[WIDTH_DOUT-1 -: 8];
                tx_valid <= 1'b1;
                count    <= '0;
                state    <= SEND;
            end

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data[7:6] == 2'b10) begin
                            control <= rx_data[5:0];
                            count   <= '0;
                            busy    <= 1'b1;
                            state   <= LOAD;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (rx_valid) begin
                        din <= {din[WIDTH_DIN-9:0], rx_data};
                        if (count == CW'(NIN - 1)) begin
                            count     <= '0;
                            din_valid <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    din_valid <= 1'b0;
`ifdef COPRO_SEQ_TIMEOUT_EN
                    wcnt <= '0;
`endif
                    if (!capture)
                        state <= WAIT;
                end
                WAIT: begin
`ifdef COPRO_SEQ_TIMEOUT_EN
                    if (!capture) begin
                        if (wcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            tx_data  <= 8'hEE;
                            tx_valid <= 1'b1;
                            state    <= ERR;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
`endif
                end
                SEND: begin
                    if (tx_valid && tx_ready) begin
                        if (count == CW'(NOUT - 1)) begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            count    <= '0;
                            state    <= IDLE;
                        end else begin
                            shreg   <= {shreg[WIDTH_DOUT-9:0], 8'h00};
                            tx_data <= shreg[WIDTH_DOUT-9 -: 8];
                            count   <= count + 1'b1;
                        end
                    end
                end
                ERR: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_copro_frame_sequencer.sv
// Self-checking bench: echo coprocessor model plus a byte-queue scoreboard
// for the tx stream, with directed frames and literal pins.
module tb_copro_frame_sequencer;
    localparam int unsigned TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   rx_data = '0;
    logic         rx_valid = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b1;
    logic [127:0] din;
    logic         din_valid;
    logic [127:0] dout;
    logic         dout_valid;
    logic [5:0]   control;
    logic         busy;
    logic         overrun;

    copro_frame_sequencer #(
        .WIDTH_DIN(128),
        .WIDTH_DOUT(128),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid),
        .control(control), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Coprocessor model: echoes the issued operand after lat cycles, or combinationally.
    int unsigned  lat = 3;
    bit           copro_en = 1'b1;
    bit           zero_lat = 1'b0;
    logic [127:0] dly_word = '0;
    logic         dly_valid = 1'b0;

    assign dout_valid = zero_lat ? (din_valid && copro_en) : dly_valid;
    assign dout       = zero_lat ? din : dly_word;

    always begin
        @(negedge clk);
        if (din_valid && copro_en && !zero_lat) begin
            dly_word = din;
            repeat (lat) @(posedge clk);
            #1 dly_valid = 1'b1;
            @(posedge clk);
            #1 dly_valid = 1'b0;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Scoreboard state: expected tx bytes, operand word and mode.
    logic [7:0]   q[$];
    logic [127:0] exp_din = '0;
    logic [5:0]   exp_ctrl = '0;
    int           acc_cnt = 0;
    int           dv_cnt = 0;
    logic         pv = 0, pr = 0, pdv = 0;
    logic [7:0]   pd = '0;

    always @(negedge clk) begin
        if (rst) begin
            pv = 0; pr = 0; pdv = 0;
        end else begin
            if (pv && !pr) begin
                chk("tx_hold_valid", tx_valid, 1);
                chk("tx_hold_data", tx_data, pd);
            end
            if (tx_valid && tx_ready) begin
                if (q.size() == 0) fail_now("tx_unexpected_byte");
                else begin
                    chk("tx_byte", tx_data, q.pop_front());
                    acc_cnt++;
                end
            end
            if (din_valid) begin
                chk("din_word", din, exp_din);
                chk("din_control", control, exp_ctrl);
                chk("din_valid_single", pdv, 0);
                dv_cnt++;
            end
            pv = tx_valid; pr = tx_ready; pd = tx_data; pdv = din_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [5:0] ctrl, input logic [7:0] base, input bit echo);
        exp_ctrl = ctrl;
        for (int i = 0; i < 16; i++) begin
            exp_din[127-8*i -: 8] = 8'(base + i);
            if (echo) q.push_back(8'(base + i));
        end
        send_byte({2'b10, ctrl});
        for (int i = 0; i < 16; i++) send_byte(8'(base + i));
    endtask

    task automatic wait_drain(input string nm, input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) tick(1);
        if (q.size() != 0) fail_now(nm);
        tick(1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        q.delete();
        acc_cnt = 0;
        dv_cnt = 0;
    endtask

    initial begin
        tick(1);
        chk("rst_din", din, 0);
        chk("rst_din_valid", din_valid, 0);
        chk("rst_control", control, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick(1);

        // Basic frame, echo after 3 cycles.
        send_frame(6'h01, 8'h00, 1);
        wait_drain("frame1_timeout", 200);
        chk("f1_busy_end", busy, 0);
        chk("f1_control", control, 6'h01);
        chk("f1_din", din, 128'h000102030405060708090a0b0c0d0e0f);
        chk("f1_din_valid_count", dv_cnt, 1);
        chk("f1_tx_count", acc_cnt, 16);
        chk("f1_overrun", overrun, 0);

        // Backpressure on byte 7.
        acc_cnt = 0;
        send_frame(6'h01, 8'h00, 1);
        begin
            int i;
            for (i = 0; i < 200 && !(acc_cnt == 7 && tx_valid); i++) tick(1);
            if (i >= 200) fail_now("stall_wait_timeout");
        end
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("stall_tx_data", tx_data, 8'h07);
            chk("stall_tx_valid", tx_valid, 1);
        end
        tx_ready = 1'b1;
        wait_drain("frame2_timeout", 200);
        chk("f2_tx_count", acc_cnt, 16);
        chk("f2_din_valid_count", dv_cnt, 2);

        // Bad header in IDLE.
        send_byte(8'h45);
        tick(1);
        chk("bad_hdr_overrun", overrun, 1);
        chk("bad_hdr_idle", busy, 0);

        // Extra rx byte during WAIT.
        pulse_reset();
        chk("ovr_cleared_by_rst", overrun, 0);
        lat = 8;
        send_frame(6'h01, 8'h10, 1);
        begin
            int i;
            for (i = 0; i < 100 && dv_cnt == 0; i++) tick(1);
            if (i >= 100) fail_now("issue_wait_timeout");
        end
        send_byte(8'h5A);
        chk("wait_rx_overrun", overrun, 1);
        chk("wait_rx_busy", busy, 1);
        wait_drain("frame3_timeout", 200);
        chk("f3_tx_count", acc_cnt, 16);
        chk("f3_busy_end", busy, 0);
        lat = 3;

        // Asynchronous reset after 9 payload bytes.
        pulse_reset();
        send_byte(8'h81);
        for (int i = 0; i < 9; i++) send_byte(8'(i));
        #2 rst = 1'b1;
        #1;
        chk("arst_din", din, 0);
        chk("arst_control", control, 0);
        chk("arst_busy", busy, 0);
        chk("arst_tx_valid", tx_valid, 0);
        chk("arst_tx_data", tx_data, 0);
        chk("arst_din_valid", din_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(40);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_din_valid_count", dv_cnt, 0);
        send_frame(6'h02, 8'hA0, 1);
        wait_drain("frame4_timeout", 200);
        chk("f4_control", control, 6'h02);
        chk("f4_din", din, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
        chk("f4_tx_count", acc_cnt, 16);

        // Result returned in the ISSUE cycle.
        acc_cnt = 0;
        zero_lat = 1'b1;
        send_frame(6'h3F, 8'h30, 1);
        wait_drain("frame5_timeout", 200);
        chk("f5_tx_count", acc_cnt, 16);
        chk("f5_busy_end", busy, 0);
        zero_lat = 1'b0;

        // Coprocessor never answers.
        copro_en = 1'b0;
        acc_cnt = 0;
`ifdef COPRO_SEQ_TIMEOUT_EN
        q.push_back(8'hEE);
        send_frame(6'h05, 8'h50, 0);
        wait_drain("timeout_err_byte", 100);
        chk("to_tx_count", acc_cnt, 1);
        chk("to_busy_end", busy, 0);
`else
        send_frame(6'h05, 8'h50, 0);
        tick(60);
        chk("nowd_busy", busy, 1);
        chk("nowd_tx_valid", tx_valid, 0);
        pulse_reset();
        chk("nowd_rst_busy", busy, 0);
`endif
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench time limit exceeded");
    end
endmodule

// File: doc/copro_frame_sequencer.md
COPRO_FRAME_SEQUENCER -- requirements
Module: copro_frame_sequencer

Interface
REQ-001 Parameter WIDTH_DIN, 128, coprocessor input word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter WIDTH_DOUT, 128, coprocessor output word width in bits; SHALL be a multiple of 8.
REQ-003 Parameter TIMEOUT_CYCLES, 1024, maximum cycles to wait for a coprocessor result.
REQ-004 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 rx_data  in  8  byte from UART receiver.
REQ-007 rx_valid  in  1  one-cycle strobe: rx_data valid.
REQ-008 tx_data  out  8  byte to UART transmitter.
REQ-009 tx_valid  out  1  tx_data valid; held until accepted.
REQ-010 tx_ready  in  1  transmitter accepts when tx_valid && tx_ready.
REQ-011 din  out  WIDTH_DIN  operand word to coprocessor.
REQ-012 din_valid  out  1  one-cycle issue strobe to coprocessor.
REQ-013 dout  in  WIDTH_DOUT  coprocessor result.
REQ-014 dout_valid  in  1  one-cycle result strobe.
REQ-015 control  out  6  coprocessor mode select.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 overrun  out  1  sticky: rx byte dropped or bad header seen.

Function
REQ-018 States SHALL be IDLE, LOAD, ISSUE, WAIT, SEND, ERR.
REQ-019 IDLE: rx_valid with rx_data[7:6]==2'b10 -> control<=rx_data[5:0], byte count<=0, go LOAD; any other rx byte -> set overrun, stay IDLE.
REQ-020 LOAD: each rx_valid shifts byte into din, first byte landing in din[WIDTH_DIN-1 -: 8] (MSB-first); after WIDTH_DIN/8 bytes go ISSUE.
REQ-021 din SHALL stay stable from ISSUE until the next LOAD begins.
REQ-022 ISSUE: din_valid=1 for exactly one cycle, then WAIT.
REQ-023 WAIT: dout_valid captures dout into output shift register, go SEND; dout_valid in ISSUE itself SHALL also be captured (zero-latency coprocessor).
REQ-024 dout_valid in IDLE, LOAD, SEND or ERR SHALL be ignored.
REQ-025 SEND: present result MSB-first, one byte per tx_valid&&tx_ready; tx_data and tx_valid SHALL not change while tx_valid && !tx_ready; after WIDTH_DOUT/8 accepted bytes go IDLE.
REQ-026 rx_valid in ISSUE, WAIT, SEND or ERR: byte dropped, overrun set.
REQ-027 control SHALL hold its value until the next valid header; din_valid low outside ISSUE.
REQ-028 Byte counters SHALL be sized ceil(log2(max(WIDTH_DIN,WIDTH_DOUT)/8+1)) bits; no wrap within a frame.
REQ-029 overrun clears only on reset.

Reset
REQ-030 rst high, any state or mid-frame: state<=IDLE, counters<=0, din<=0, din_valid<=0, control<=0, tx_data<=0, tx_valid<=0, busy<=0, overrun<=0, immediately and without waiting for clk.
REQ-031 Partially loaded or partially sent frames SHALL be discarded on reset; no bytes are emitted afterwards.

Configuration
REQ-032 Macro COPRO_SEQ_TIMEOUT_EN enables a WAIT watchdog.
REQ-033 With macro: WAIT cycle counter; on reaching TIMEOUT_CYCLES without dout_valid go ERR, emit single byte 8'hEE via tx handshake, then IDLE; dout_valid arriving on the timeout cycle wins (go SEND).
REQ-034 Without macro: no counter, no ERR entry; WAIT holds indefinitely until dout_valid or reset.

Verification
REQ-035 Header 8'h81, bytes 00..0F, coprocessor echoes din after 3 cycles -> control=6'h01, one din_valid with din=128'h000102..0F, tx bytes 00..0F in order, busy low after last byte.
REQ-036 Same frame, tx_ready low 5 cycles on byte 7 -> tx_data=8'h07 and tx_valid held steady; total 16 bytes, none duplicated.
REQ-037 Byte 8'h45 in IDLE, then extra rx byte during WAIT -> overrun=1, state IDLE after first, WAIT unaffected after second.
REQ-038 rst pulsed after 9 payload bytes -> all outputs zero asynchronously; new frame header 8'h82 then processes normally with control=6'h02.
REQ-039 With COPRO_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, no dout_valid -> single tx byte 8'hEE, then IDLE; without macro -> busy stays high.
REQ-040 dout_valid in same cycle as din_valid -> result captured, 16 bytes sent.
